// File: rtl/reg_hex_display_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_hex_display_pkg
// Purpose  : Shared constants and the nibble-to-segment decoder for the
//            8-digit hex register display.
// Revision : 1.0 - initial release
// ============================================================================
package reg_hex_display_pkg;

    localparam int NUM_DIGITS = 8;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Map one hex nibble onto its active-low segment pattern
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] w_seg;
        w_seg = SEG_BLANK;
        case (nibble)
            4'h0: w_seg = SEG_0;
            4'h1: w_seg = SEG_1;
            4'h2: w_seg = SEG_2;
            4'h3: w_seg = SEG_3;
            4'h4: w_seg = SEG_4;
            4'h5: w_seg = SEG_5;
            4'h6: w_seg = SEG_6;
            4'h7: w_seg = SEG_7;
            4'h8: w_seg = SEG_8;
            4'h9: w_seg = SEG_9;
            4'hA: w_seg = SEG_A;
            4'hB: w_seg = SEG_B;
            4'hC: w_seg = SEG_C;
            4'hD: w_seg = SEG_D;
            4'hE: w_seg = SEG_E;
            4'hF: w_seg = SEG_F;
            default: w_seg = SEG_BLANK;
        endcase
        return w_seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// Module   : button_debounce
// Purpose  : Two-flop synchronizer, stability-count debouncer and a single
//            press pulse on each accepted rising edge of a raw pushbutton.
// Revision : 1.0 - initial release
// ============================================================================
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_button,
    output logic o_press
);

    localparam int             CNT_W     = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       r_sync;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;

    // Bring the asynchronous button level into the clock domain
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], i_button};
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES
    // consecutive cycles; the pulse is raised in the same cycle the level
    // rises, so holding the button yields exactly one pulse
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_press <= 1'b0;
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_max) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
                r_press <= r_sync[1];
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_press = r_press;

endmodule
`default_nettype wire

// File: rtl/reg_hex_display.sv
`default_nettype none
// ============================================================================
// Module   : reg_hex_display
// Purpose  : Shows one of two 32-bit register taps in hex on an 8-digit
//            multiplexed common-anode display. Buttons select the source and
//            freeze the display; the shown value only changes at frame wrap.
// Revision : 1.0 - initial release
// ============================================================================
module reg_hex_display
    import reg_hex_display_pkg::*;
#(
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_reg1,
    input  logic [31:0] data_reg2,
    input  logic        sel_button,
    input  logic        freeze_button,
    output logic [6:0]  seg,
    output logic [7:0]  an,
    output logic        dp,
    output logic        sel_led,
    output logic        frozen_led
);

    localparam int               PRE_W     = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PRE_W-1:0] c_pre_max = PRE_W'(SCAN_DIV - 1);
    localparam int               DIG_W     = $clog2(NUM_DIGITS);
    localparam logic [DIG_W-1:0] c_dig_max = DIG_W'(NUM_DIGITS - 1);

    logic             w_sel_press;
    logic             w_frz_press;
    logic             w_terminal;
    logic             w_frame_wrap;
    logic [3:0]       w_nibble;

    logic [PRE_W-1:0] r_prescale;
    logic [DIG_W-1:0] r_digit;
    logic [31:0]      r_snapshot;
    logic             r_select;
    logic             r_freeze;
    logic [6:0]       r_seg;
    logic [7:0]       r_an;
    logic             r_dp;

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sel_debounce (
        .i_clk    (clock),
        .i_rst_n  (reset),
        .i_button (sel_button),
        .o_press  (w_sel_press)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_frz_debounce (
        .i_clk    (clock),
        .i_rst_n  (reset),
        .i_button (freeze_button),
        .o_press  (w_frz_press)
    );

    assign w_terminal   = (r_prescale == c_pre_max);
    assign w_frame_wrap = w_terminal && (r_digit == c_dig_max);
    assign w_nibble     = r_snapshot[{r_digit, 2'b00} +: 4];

    // Each press toggles its mode; simultaneous presses both take effect
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_select <= 1'b0;
            r_freeze <= 1'b0;
        end else begin
            r_select <= r_select ^ w_sel_press;
            r_freeze <= r_freeze ^ w_frz_press;
        end
    end

    // Digit scan: prescaler sets the per-digit dwell, digit wraps every frame
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_prescale <= '0;
            r_digit    <= '0;
        end else if (w_terminal) begin
            r_prescale <= '0;
            r_digit    <= r_digit + 1'b1;
        end else begin
            r_prescale <= r_prescale + 1'b1;
        end
    end

    // Sample the selected register only at frame wrap so digits never tear
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_snapshot <= '0;
        end else if (w_frame_wrap && !r_freeze) begin
            r_snapshot <= r_select ? data_reg2 : data_reg1;
        end
    end

    // Register the pad drives one cycle behind digit index and snapshot
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_an  <= 8'hFE;
            r_seg <= SEG_0;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= ~(NUM_DIGITS'(1) << r_digit);
            r_seg <= hex_to_seg(w_nibble);
            r_dp  <= ~((r_digit == '0) && r_freeze);
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign sel_led    = r_select;
    assign frozen_led = r_freeze;

endmodule
`default_nettype wire

// File: tb/tb_reg_hex_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_hex_display
// Purpose  : Randomized self-checking bench for reg_hex_display with a
//            cycle-count based reference model of scan, snapshot and modes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_hex_display;

    localparam int SCAN_DIV  = 4;
    localparam int DEB       = 8;
    localparam int FRAME     = 8 * SCAN_DIV;
    localparam int NFRAMES   = 45;
    localparam int RST_FRAME = 30;

    localparam int ACT_NONE   = 0;
    localparam int ACT_SEL    = 1;
    localparam int ACT_FRZ    = 2;
    localparam int ACT_BOTH   = 3;
    localparam int ACT_SHORT  = 4;
    localparam int ACT_BOUNCE = 5;

    localparam logic [6:0] SEG_REF [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] data_reg1;
    logic [31:0] data_reg2;
    logic        sel_button;
    logic        freeze_button;
    logic [6:0]  seg;
    logic [7:0]  an;
    logic        dp;
    logic        sel_led;
    logic        frozen_led;

    int          vectors    = 0;
    int          miscompares = 0;
    int          n;
    logic [31:0] m_snap;
    logic        m_sel;
    logic        m_frz;
    logic        chk_state;

    reg_hex_display #(
        .SCAN_DIV        (SCAN_DIV),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .data_reg1     (data_reg1),
        .data_reg2     (data_reg2),
        .sel_button    (sel_button),
        .freeze_button (freeze_button),
        .seg           (seg),
        .an            (an),
        .dp            (dp),
        .sel_led       (sel_led),
        .frozen_led    (frozen_led)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at t=%0t n=%0d: got %h expected %h", tag, $time, n, got, exp);
        end
    endtask

    task automatic model_reset();
        n      = 0;
        m_snap = 32'h0;
        m_sel  = 1'b0;
        m_frz  = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_an"},  32'(an),         32'h0000_00FE);
        check({tag, "_seg"}, 32'(seg),        32'h0000_0040);
        check({tag, "_dp"},  32'(dp),         32'h1);
        check({tag, "_sel"}, 32'(sel_led),    32'h0);
        check({tag, "_frz"}, 32'(frozen_led), 32'h0);
    endtask

    // One clock: compare the pads against the cycle-count model, then let
    // the model see a frame wrap if this edge was one
    task automatic step();
        int         digit;
        logic [3:0] nib;
        logic [7:0] exp_an;
        logic       exp_dp;
        @(posedge clock);
        #1;
        n++;
        digit  = ((n - 1) / SCAN_DIV) % 8;
        nib    = 4'(m_snap >> (4 * digit));
        exp_an = ~(8'h01 << digit);
        exp_dp = !(digit == 0 && m_frz);
        check("an",  32'(an),  32'(exp_an));
        check("seg", 32'(seg), 32'(SEG_REF[nib]));
        if (chk_state) begin
            check("dp",         32'(dp),         32'(exp_dp));
            check("sel_led",    32'(sel_led),    32'(m_sel));
            check("frozen_led", 32'(frozen_led), 32'(m_frz));
        end
        if ((n % FRAME) == 0 && !m_frz) begin
            m_snap = m_sel ? data_reg2 : data_reg1;
        end
    endtask

    initial begin
        int act;
        reset         = 1'b0;
        sel_button    = 1'b0;
        freeze_button = 1'b0;
        data_reg1     = 32'h89AB_CDEF;
        data_reg2     = 32'h1234_5678;
        chk_state     = 1'b0;
        model_reset();

        repeat (3) @(posedge clock);
        #1;
        check_reset_state("rst");
        reset = 1'b1;

        for (int f = 0; f < NFRAMES; f++) begin
            case (f)
                0, 5, 6, 8: act = ACT_NONE;
                1:          act = ACT_SHORT;
                2:          act = ACT_SEL;
                3:          act = ACT_BOUNCE;
                4, 7:       act = ACT_FRZ;
                default:    act = int'($urandom_range(0, 5));
            endcase
            if (f == RST_FRAME - 1) act = m_frz ? ACT_NONE : ACT_FRZ;
            if (f == RST_FRAME)     act = ACT_NONE;
            if (f == 5)             data_reg1 = 32'h0;

            for (int c = 0; c < FRAME; c++) begin
                sel_button    = 1'b0;
                freeze_button = 1'b0;
                case (act)
                    ACT_SEL:    sel_button = (c >= 1 && c <= 12);
                    ACT_FRZ:    freeze_button = (c >= 1 && c <= 12);
                    ACT_BOTH: begin
                        sel_button    = (c >= 1 && c <= 12);
                        freeze_button = (c >= 1 && c <= 12);
                    end
                    ACT_SHORT:  sel_button = (c >= 1 && c <= 5);
                    ACT_BOUNCE: sel_button = (c >= 1 && c <= 21) && (((c - 1) / 3) % 2 == 0);
                    default:    ;
                endcase
                if (f >= 8) begin
                    if ($urandom_range(0, 3) == 0) data_reg1 = $urandom;
                    if ($urandom_range(0, 3) == 0) data_reg2 = $urandom;
                end
                if (c == 26) begin
                    if (act == ACT_SEL || act == ACT_BOTH) m_sel = ~m_sel;
                    if (act == ACT_FRZ || act == ACT_BOTH) m_frz = ~m_frz;
                end
                chk_state = (c >= 26) || (c <= 1);
                step();
                if (f == RST_FRAME && c == 21) begin
                    sel_button    = 1'b0;
                    freeze_button = 1'b0;
                    #2 reset = 1'b0;
                    #1;
                    check_reset_state("async_rst");
                    repeat (2) @(posedge clock);
                    #1;
                    check_reset_state("rst_hold");
                    reset = 1'b1;
                    model_reset();
                    break;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
